// File: rtl/intra_tu_sched_pkg.sv
// Shared definitions for the intra TU scheduler: field widths, FSM encoding,
// component indices and the minimum TU size.
package intra_tu_sched_pkg;

  localparam int unsigned CTB_W       = 9;
  localparam int unsigned REL_W       = 4;
  localparam int unsigned SZ_W        = 3;
  localparam int unsigned POS_W       = 13;
  localparam int unsigned CIDX_W      = 2;
  localparam int unsigned MIN_TU_LOG2 = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LUMA = 2'd1,
    ST_CB   = 2'd2,
    ST_CR   = 2'd3
  } state_e;

  localparam logic [CIDX_W-1:0] CIDX_Y  = 2'd0;
  localparam logic [CIDX_W-1:0] CIDX_CB = 2'd1;
  localparam logic [CIDX_W-1:0] CIDX_CR = 2'd2;

endpackage

// File: rtl/intra_tb_coord.sv
// Combinational TU coordinate generator: absolute luma position, or the
// matching 4:2:0 chroma position and size when isChroma is set.
module intra_tb_coord
  import intra_tu_sched_pkg::*;
#(
  parameter bit isChroma = 1'b0
) (
  input  logic [CTB_W-1:0] xCtb,
  input  logic [CTB_W-1:0] yCtb,
  input  logic [REL_W-1:0] xTb_rela,
  input  logic [REL_W-1:0] yTb_rela,
  input  logic [SZ_W-1:0]  i_tuSize,
  output logic [POS_W-1:0] x_tb,
  output logic [POS_W-1:0] y_tb,
  output logic [SZ_W-1:0]  tu_size
);

  logic [POS_W-1:0] x_l;
  logic [POS_W-1:0] y_l;

  always_comb begin
    x_l     = (POS_W'(xCtb) << 4) + (POS_W'(xTb_rela) << 2);
    y_l     = (POS_W'(yCtb) << 4) + (POS_W'(yTb_rela) << 2);
    x_tb    = x_l;
    y_tb    = y_l;
    tu_size = i_tuSize;
    if (isChroma) begin
      // A 4x4 quad's chroma belongs to the quad origin, one 4x4 up-left.
      if (i_tuSize == SZ_W'(MIN_TU_LOG2)) begin
        x_tb    = (x_l - POS_W'(4)) >> 1;
        y_tb    = (y_l - POS_W'(4)) >> 1;
        tu_size = SZ_W'(MIN_TU_LOG2);
      end else begin
        x_tb    = x_l >> 1;
        y_tb    = y_l >> 1;
        tu_size = i_tuSize - SZ_W'(1);
      end
    end
  end

endmodule

// File: rtl/intra_tu_sched.sv
// Intra TU command scheduler: turns one TU descriptor into a Y command and,
// when due, Cb and Cr commands, with registered valid/ready handshakes.
module intra_tu_sched
  import intra_tu_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTB_W-1:0]  xCtb,
  input  logic [CTB_W-1:0]  yCtb,
  input  logic [REL_W-1:0]  xTb_rela,
  input  logic [REL_W-1:0]  yTb_rela,
  input  logic [SZ_W-1:0]   i_tuSize,
  input  logic              last_tu,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CIDX_W-1:0] out_cIdx,
  output logic [POS_W-1:0]  out_xTb,
  output logic [POS_W-1:0]  out_yTb,
  output logic [SZ_W-1:0]   out_tuSize,
  output logic              ctb_done,
  output logic [CNT_W-1:0]  cmd_cnt
);

  state_e            state_q, state_d;
  logic [CTB_W-1:0]  x_ctb_q, x_ctb_d, y_ctb_q, y_ctb_d;
  logic [REL_W-1:0]  x_rela_q, x_rela_d, y_rela_q, y_rela_d;
  logic [SZ_W-1:0]   size_q, size_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [CIDX_W-1:0] out_cidx_q, out_cidx_d;
  logic [POS_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic [SZ_W-1:0]   out_size_q, out_size_d;
  logic              in_ready_q, in_ready_d;
  logic              ctb_done_q, ctb_done_d;
  logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;

  logic [POS_W-1:0]  luma_x, luma_y, chroma_x, chroma_y;
  logic [SZ_W-1:0]   luma_size, chroma_size;
  logic              accept, out_hs, chroma_due;

  // Luma position comes straight from the incoming descriptor at accept time.
  intra_tb_coord #(.isChroma(1'b0)) u_luma_coord (
    .xCtb(xCtb), .yCtb(yCtb), .xTb_rela(xTb_rela), .yTb_rela(yTb_rela),
    .i_tuSize(i_tuSize), .x_tb(luma_x), .y_tb(luma_y), .tu_size(luma_size)
  );

  intra_tb_coord #(.isChroma(1'b1)) u_chroma_coord (
    .xCtb(x_ctb_q), .yCtb(y_ctb_q), .xTb_rela(x_rela_q), .yTb_rela(y_rela_q),
    .i_tuSize(size_q), .x_tb(chroma_x), .y_tb(chroma_y), .tu_size(chroma_size)
  );

  assign accept     = in_valid & in_ready_q;
  assign out_hs     = out_valid_q & out_ready;
  assign chroma_due = (size_q != SZ_W'(MIN_TU_LOG2)) | (x_rela_q[0] & y_rela_q[0]);

  always_comb begin
    state_d     = state_q;
    x_ctb_d     = x_ctb_q;
    y_ctb_d     = y_ctb_q;
    x_rela_d    = x_rela_q;
    y_rela_d    = y_rela_q;
    size_d      = size_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_cidx_d  = out_cidx_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_size_d  = out_size_q;
    in_ready_d  = in_ready_q;
    ctb_done_d  = 1'b0;
    cmd_cnt_d   = cmd_cnt_q + CNT_W'(out_hs);

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          x_ctb_d     = xCtb;
          y_ctb_d     = yCtb;
          x_rela_d    = xTb_rela;
          y_rela_d    = yTb_rela;
          size_d      = i_tuSize;
          last_d      = last_tu;
          state_d     = ST_LUMA;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_cidx_d  = CIDX_Y;
          out_x_d     = luma_x;
          out_y_d     = luma_y;
          out_size_d  = luma_size;
        end
      end
      ST_LUMA: begin
        if (out_hs) begin
          if (chroma_due) begin
            state_d    = ST_CB;
            out_cidx_d = CIDX_CB;
            out_x_d    = chroma_x;
            out_y_d    = chroma_y;
            out_size_d = chroma_size;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            ctb_done_d  = last_q;
          end
        end
      end
      ST_CB: begin
        if (out_hs) begin
          state_d    = ST_CR;
          out_cidx_d = CIDX_CR;
        end
      end
      ST_CR: begin
        if (out_hs) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          ctb_done_d  = last_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_ctb_q     <= '0;
      y_ctb_q     <= '0;
      x_rela_q    <= '0;
      y_rela_q    <= '0;
      size_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_cidx_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_size_q  <= '0;
      in_ready_q  <= 1'b0;
      ctb_done_q  <= 1'b0;
      cmd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_ctb_q     <= x_ctb_d;
      y_ctb_q     <= y_ctb_d;
      x_rela_q    <= x_rela_d;
      y_rela_q    <= y_rela_d;
      size_q      <= size_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_cidx_q  <= out_cidx_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_size_q  <= out_size_d;
      in_ready_q  <= in_ready_d;
      ctb_done_q  <= ctb_done_d;
      cmd_cnt_q   <= cmd_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_cIdx   = out_cidx_q;
  assign out_xTb    = out_x_q;
  assign out_yTb    = out_y_q;
  assign out_tuSize = out_size_q;
  assign ctb_done   = ctb_done_q;
  assign cmd_cnt    = cmd_cnt_q;

endmodule
